// File: rtl/mem_ctrl_pkg.sv
// Shared select codes, FSM encoding and size helper for the byte-serial memory responder.
package mem_ctrl_pkg;

  typedef logic [1:0] mem_sel_t;

  localparam mem_sel_t MEM_NOP  = 2'd0;
  localparam mem_sel_t MEM_BYTE = 2'd1;
  localparam mem_sel_t MEM_HALF = 2'd2;
  localparam mem_sel_t MEM_WORD = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRD   = 3'd1,
    DWR   = 3'd2,
    IRD   = 3'd3,
    DDONE = 3'd4,
    IDONE = 3'd5
  } mem_state_e;

  localparam int CNT_W = 3;

  function automatic logic [CNT_W-1:0] sel_len(input mem_sel_t sel);
    case (sel)
      MEM_BYTE: return 3'd1;
      MEM_HALF: return 3'd2;
      MEM_WORD: return 3'd4;
      default:  return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Sign or zero extension of an assembled load value to 32 bits.
module mem_load_ext
  import mem_ctrl_pkg::*;
(
  input  mem_sel_t    sel,
  input  logic        sign,
  input  logic [31:0] data,
  output logic [31:0] ext
);

  always_comb begin
    case (sel)
      MEM_BYTE: ext = {{24{sign & data[7]}}, data[7:0]};
      MEM_HALF: ext = {{16{sign & data[15]}}, data[15:0]};
      default:  ext = data;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Serialises MEM-stage data and IF-stage fetch requests onto one byte-wide RAM port,
// little-endian, with data accesses taking priority over fetches.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int INST_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_req,
  input  logic              d_we,
  input  mem_sel_t          d_sel,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic              d_load_sign,
  output logic [31:0]       d_rdata,
  output logic              d_done,
  output logic              d_stall_req,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_done,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  output logic              mem_wr,
  input  logic [7:0]        mem_din
);

  mem_state_e        state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  a_off;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       buf_q;
  logic [31:0]       merged;
  logic [31:0]       ext_val;
  mem_sel_t          sel_q;
  logic              sign_q;
  logic              d_valid;
  logic              rd_busy;

  assign d_valid     = d_req && (d_sel != MEM_NOP);
  assign d_stall_req = d_valid && !d_done;
  assign rd_busy     = (state == DRD) || (state == IRD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Read states run one extra cycle (cnt == len_q) to capture the last byte.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (d_valid)    state_nx = d_we ? DWR : DRD;
        else if (i_req) state_nx = IRD;
      end
      DWR: begin
        if (cnt == len_q - 3'd1) begin
          state_nx = DDONE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 3'd1;
        end
      end
      DRD: begin
        if (cnt == len_q) begin
          state_nx = DDONE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 3'd1;
        end
      end
      IRD: begin
        if (!i_req) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == len_q) begin
          state_nx = IDONE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 3'd1;
        end
      end
      DDONE:   state_nx = IDLE;
      IDONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign a_off = (cnt == len_q) ? cnt - 3'd1 : cnt;

  always_comb begin
    mem_a    = '0;
    mem_wr   = 1'b0;
    mem_dout = '0;
    d_done   = 1'b0;
    i_done   = 1'b0;
    case (state)
      DWR: begin
        mem_a    = addr_q + ADDR_W'(cnt);
        mem_wr   = 1'b1;
        mem_dout = wdata_q[{cnt[1:0], 3'b000} +: 8];
      end
      DRD, IRD: mem_a = addr_q + ADDR_W'(a_off);
      DDONE:    d_done = 1'b1;
      IDONE:    i_done = 1'b1;
      default:  ;
    endcase
  end

  // Byte k of a read arrives while cnt == k+1.
  always_comb begin
    merged = buf_q;
    case (cnt)
      3'd1:    merged[7:0]   = mem_din;
      3'd2:    merged[15:8]  = mem_din;
      3'd3:    merged[23:16] = mem_din;
      3'd4:    merged[31:24] = mem_din;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      if (d_valid) begin
        addr_q  <= d_addr;
        wdata_q <= d_wdata;
        sel_q   <= d_sel;
        sign_q  <= d_load_sign;
        len_q   <= sel_len(d_sel);
      end else begin
        addr_q <= i_addr;
        len_q  <= CNT_W'(INST_BYTES);
      end
    end
    if (rd_busy && cnt != '0) buf_q <= merged;
  end

  mem_load_ext u_ext (
    .sel  (sel_q),
    .sign (sign_q),
    .data (merged),
    .ext  (ext_val)
  );

  // Results are registered on the final capture so they hold between done pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_rdata <= '0;
      i_rdata <= '0;
    end else begin
      if (state == DRD && cnt == len_q)          d_rdata <= ext_val;
      if (state == IRD && cnt == len_q && i_req) i_rdata <= merged;
    end
  end

endmodule
